pipe_hazard_ctrl: RTL

- Central pipeline controller for the 4-stage 8-bit core (IF, ID, EX, WB).
- Decodes the instruction held in the IF/ID register and keeps shadow copies of the EX and WB stage contents.
- Drives the write enables, flush and bubble controls for the PC, IF/ID and stage registers, plus the operand-forwarding selects.
- Sequences load-use stalls, multi-cycle loads, taken-branch flushes and HALT drain.

---
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the 4-stage datapath and the hazard controller.
// The controller sits on the slave modport; the datapath (or bench) drives the master side.
interface pipe_hazard_ctrl_if;
    logic [15:0] id_ins;
    logic [1:0]  ex_zn;
    logic        pc_we;
    logic        pc_sel_br;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_bubble;
    logic        exwb_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        halted;
    logic [1:0]  fsm_state;

    // All signals are level controls sampled at the rising clock edge; there is no
    // valid/ready pair, a stall is expressed purely by the write enables dropping.
    modport master (
        output id_ins, ex_zn,
        input  pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_bubble,
               exwb_bubble, fwd_a, fwd_b, halted, fsm_state
    );

    modport slave (
        input  id_ins, ex_zn,
        output pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_bubble,
               exwb_bubble, fwd_a, fwd_b, halted, fsm_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the IF/ID/EX/WB 8-bit core: stalls, flushes, forwarding
// selects and HALT drain, driven from shadow copies of the EX and WB stages.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LD_WAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BR   = 4'h9;
    localparam logic [3:0] OP_BRZ  = 4'hA;
    localparam logic [3:0] OP_BRN  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;
    localparam bit         LD_LONG = (LOAD_LAT > 1);
    localparam logic [1:0] LD_CNT  = 2'(LOAD_LAT - 1);

    state_t     state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic       ld_held, ld_held_nx;

    logic       ex_valid;
    logic [3:0] ex_op;
    logic [1:0] ex_rd;
    logic       wb_valid;
    logic       wb_wr;
    logic [1:0] wb_rd;

    logic [3:0] id_op;
    logic [1:0] id_ra, id_rb;
    logic       reads_ra, reads_rb, ex_wr, ex_is_ld, load_use, taken, id_halt;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       unused_imm;

    logic       pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_bubble;
    logic       exwb_bubble, halted;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic op_writes(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

    function automatic logic [1:0] fwd_src(input logic [1:0] src);
        if (ex_valid && ex_wr && (ex_op != OP_LD) && (ex_rd == src))
            return 2'b01;
        else if (wb_valid && wb_wr && (wb_rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign id_op      = bus.id_ins[15:12];
    assign id_ra      = bus.id_ins[11:10];
    assign id_rb      = bus.id_ins[9:8];
    assign unused_imm = ^bus.id_ins[7:0];

    assign reads_ra = ((id_op >= 4'h1) && (id_op <= 4'h5)) || (id_op == OP_ST);
    assign reads_rb = (id_op >= 4'h1) && (id_op <= 4'h4);
    assign ex_wr    = op_writes(ex_op);
    assign ex_is_ld = ex_valid && (ex_op == OP_LD);
    assign load_use = ex_is_ld && ((reads_ra && (id_ra == ex_rd)) ||
                                   (reads_rb && (id_rb == ex_rd)));
    assign taken    = ex_valid && ((ex_op == OP_BR) ||
                                   ((ex_op == OP_BRZ) && bus.ex_zn[1]) ||
                                   ((ex_op == OP_BRN) && bus.ex_zn[0]));
    assign id_halt  = (id_op == OP_HALT);

    assign fwd_a_raw = reads_ra ? fwd_src(id_ra) : 2'b00;
    assign fwd_b_raw = reads_rb ? fwd_src(id_rb) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            cnt     <= 2'd0;
            ld_held <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ld_held <= ld_held_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ld_held_nx  = ld_held;
        pc_we       = 1'b1;
        pc_sel_br   = 1'b0;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exwb_bubble = 1'b0;
        halted      = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;

        case (state)
            S_RUN: begin
                if (taken) begin
                    pc_sel_br   = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (LD_LONG && ex_is_ld && (cnt == 2'd0) && !ld_held) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_we     = 1'b0;
                    exwb_bubble = 1'b1;
                    state_nx    = S_LD_WAIT;
                    cnt_nx      = LD_CNT;
                end else if (load_use) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_halt) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    state_nx    = S_DRAIN;
                    cnt_nx      = 2'd2;
                end
            end
            S_LD_WAIT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exwb_bubble = 1'b1;
                cnt_nx      = cnt - 2'd1;
                // ld_held keeps the same LD from re-arming the wait once back in RUN.
                if (cnt <= 2'd1) begin
                    state_nx   = S_RUN;
                    cnt_nx     = 2'd0;
                    ld_held_nx = 1'b1;
                end
            end
            S_DRAIN: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                cnt_nx      = cnt - 2'd1;
                if (cnt <= 2'd1) begin
                    state_nx = S_HALTED;
                    cnt_nx   = 2'd0;
                end
            end
            default: begin
                halted      = 1'b1;
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exwb_bubble = 1'b1;
            end
        endcase

        if (idex_we && (state != S_LD_WAIT))
            ld_held_nx = 1'b0;

        if (rst) begin
            state_nx    = S_RUN;
            cnt_nx      = 2'd0;
            ld_held_nx  = 1'b0;
            pc_we       = 1'b0;
            pc_sel_br   = 1'b0;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exwb_bubble = 1'b1;
            halted      = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end
    end

    // Shadow pipeline: mirrors what the datapath stage registers will hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= 4'h0;
            ex_rd    <= 2'd0;
            wb_valid <= 1'b0;
            wb_wr    <= 1'b0;
            wb_rd    <= 2'd0;
        end else begin
            if (idex_we) begin
                ex_valid <= !idex_bubble;
                ex_op    <= id_op;
                ex_rd    <= id_ra;
            end
            wb_valid <= !exwb_bubble && ex_valid;
            wb_wr    <= ex_wr;
            wb_rd    <= ex_rd;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.pc_sel_br   = pc_sel_br;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exwb_bubble = exwb_bubble;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.halted      = halted;
    assign bus.fsm_state   = state;
endmodule
